// File: rtl/almacen_pkg.sv
// Shared definitions for the warehouse carriage plant emulator.
// Defaults are reused by the sequencer benches.
package almacen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_REV   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int DEF_PRESCALE = 1000;
  localparam int DEF_POS_MAX  = 15;
  localparam int DEF_POS_W    = 4;

endpackage

// File: rtl/almacen_tick.sv
// Prescale counter for carriage stepping.
// Emits a one-cycle step pulse on the last count.
module almacen_tick
  import almacen_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(PRESCALE - 1));
  assign step = en && last;

  // count while enabled, wrap on step, clear on request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || step) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/almacen_planta.sv
// Carriage plant emulator: turns A/C drive commands into
// a track position and S1/S2 limit sensors, latching faults.
module almacen_planta
  import almacen_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int POS_MAX  = DEF_POS_MAX,
  parameter int POS_W    = DEF_POS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             C,
  input  logic             fault_clr,
  output logic             S1,
  output logic             S2,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             fault
);

  localparam logic [POS_W-1:0] PMAX = POS_W'(POS_MAX);

  state_t           state;
  state_t           nxt_state;
  logic [POS_W-1:0] nxt_pos;
  logic             move_ok;
  logic             step;

  // still commanded in the current travel direction
  assign move_ok = ((state == ST_FWD) && A && !C)
                || ((state == ST_REV) && C && !A);

  almacen_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!move_ok),
    .en   (move_ok),
    .step (step)
  );

  // next state and position; conflict beats everything else
  always_comb begin
    nxt_state = state;
    nxt_pos   = pos;
    if ((state != ST_FAULT) && A && C) begin
      nxt_state = ST_FAULT;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (A && (pos < PMAX)) begin
            nxt_state = ST_FWD;
          end else if (C && (pos != '0)) begin
            nxt_state = ST_REV;
          end
        end
        ST_FWD: begin
          if (!move_ok) begin
            nxt_state = ST_IDLE;
          end else if (step) begin
            nxt_pos = pos + POS_W'(1);
            if (nxt_pos == PMAX) nxt_state = ST_IDLE;
          end
        end
        ST_REV: begin
          if (!move_ok) begin
            nxt_state = ST_IDLE;
          end else if (step) begin
            nxt_pos = pos - POS_W'(1);
            if (nxt_pos == '0) nxt_state = ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (fault_clr && !A && !C) nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  // state, position and registered sensor/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      pos    <= '0;
      S1     <= 1'b0;
      S2     <= 1'b1;
      moving <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= nxt_state;
      pos    <= nxt_pos;
      S1     <= (nxt_pos == PMAX);
      S2     <= (nxt_pos == '0);
      moving <= (nxt_state == ST_FWD)
             || (nxt_state == ST_REV);
      fault  <= (nxt_state == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_almacen_planta.sv
// Scoreboard bench for almacen_planta (PRESCALE=4, POS_MAX=3).
// Stimulus queues expectations; a negedge monitor checks them.
module tb_almacen_planta;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       A = 1'b0;
  logic       C = 1'b0;
  logic       fault_clr = 1'b0;
  logic       S1, S2, moving, fault;
  logic [3:0] pos;

  int ncmp = 0;
  int nbad = 0;

  typedef struct packed {
    logic [3:0] p;
    logic       m;
    logic       f;
  } exp_t;

  exp_t  q[$];
  string tq[$];

  almacen_planta #(
    .PRESCALE(4),
    .POS_MAX (3),
    .POS_W   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .C        (C),
    .fault_clr(fault_clr),
    .S1       (S1),
    .S2       (S2),
    .pos      (pos),
    .moving   (moving),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag,
                              input logic [7:0] got,
                              input logic [7:0] want);
    ncmp++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s got{pos,S1,S2,mv,flt}=%b want=%b",
               tag, got, want);
    end
  endfunction

  function automatic logic [7:0] pack_exp(input exp_t e);
    logic s1, s2;
    s1 = (e.p == 4'd3);
    s2 = (e.p == 4'd0);
    return {e.p, s1, s2, e.m, e.f};
  endfunction

  // monitor: one registered output set per cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      string t;
      e = q.pop_front();
      t = tq.pop_front();
      chk(t, {pos, S1, S2, moving, fault}, pack_exp(e));
    end
  end

  task automatic cyc(input logic a, input logic c,
                     input logic clr, input int p,
                     input logic m, input logic f,
                     input string tag);
    exp_t e;
    #1;
    A = a;
    C = c;
    fault_clr = clr;
    @(posedge clk);
    e.p = 4'(p);
    e.m = m;
    e.f = f;
    q.push_back(e);
    tq.push_back(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r0;
    r0.p = 4'd0;
    r0.m = 1'b0;
    r0.f = 1'b0;
    #12;
    chk("reset", {pos, S1, S2, moving, fault}, pack_exp(r0));
    #1 rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 0, 0, 0, 0, $sformatf("idle%0d", i));

    // full forward travel, then end-stop with A held
    for (int j = 0; j <= 12; j++)
      cyc(1, 0, 0, j / 4, (j < 12), 0, $sformatf("fwd%0d", j));
    for (int j = 0; j < 3; j++)
      cyc(1, 0, 0, 3, 0, 0, $sformatf("fstop%0d", j));

    // reverse 6 cycles, drop, resume
    for (int j = 0; j < 6; j++)
      cyc(0, 1, 0, (j < 4) ? 3 : 2, 1, 0, $sformatf("rev%0d", j));
    cyc(0, 0, 0, 2, 0, 0, "cdrop");
    for (int j = 0; j <= 8; j++)
      cyc(0, 1, 0, (j < 4) ? 2 : ((j < 8) ? 1 : 0), (j < 8), 0,
          $sformatf("rev2_%0d", j));
    cyc(0, 0, 0, 0, 0, 0, "idle_home");

    // conflict fault and clear rules
    cyc(1, 0, 0, 0, 1, 0, "f_go0");
    cyc(1, 0, 0, 0, 1, 0, "f_go1");
    cyc(1, 1, 0, 0, 0, 1, "f_conf");
    cyc(1, 1, 1, 0, 0, 1, "f_clr_ac");
    cyc(0, 1, 1, 0, 0, 1, "f_clr_c");
    cyc(0, 0, 0, 0, 0, 1, "f_hold");
    cyc(0, 0, 1, 0, 0, 0, "f_clear");
    cyc(0, 0, 0, 0, 0, 0, "f_idle");

    // travel to pos 2 then async reset between edges
    for (int j = 0; j <= 9; j++)
      cyc(1, 0, 0, j / 4, 1, 0, $sformatf("pre_rst%0d", j));
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_rst", {pos, S1, S2, moving, fault}, pack_exp(r0));
    A = 1'b0;
    #1 rst_n = 1'b1;

    // reverse command at home is an end-stop
    for (int j = 0; j < 20; j++)
      cyc(0, 1, 0, 0, 0, 0, $sformatf("home_c%0d", j));
    cyc(0, 0, 0, 0, 0, 0, "tail");

    @(negedge clk);
    @(negedge clk);
    ncmp++;
    if (q.size() != 0) begin
      nbad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/almacen_planta.md
Name: almacen_planta

Overview:
- Hardware-in-the-loop plant emulator for the warehouse carriage: the other end of the sensor/actuator interface used by the warehouse sequencers.
- Consumes actuator commands A (drive forward) and C (drive reverse).
- Models carriage position on a discrete track and produces the limit-sensor signals S1 and S2 that the sequencer reads.
- Latches a fault on conflicting commands, so sequencers can be closed-loop tested on the board without mechanics.

Parameters:
- PRESCALE, 1000: clk cycles per one-position step while moving; legal range >= 2.
- POS_MAX, 15: far-end position, where S1 is active; home position 0 is where S2 is active.
- POS_W, 4: width of the position register; requires POS_MAX < 2**POS_W.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- A  in  1  actuator: drive carriage toward POS_MAX
- C  in  1  actuator: drive carriage toward 0
- fault_clr  in  1  clears latched fault (level, sampled at clk)
- S1  out  1  far-end limit sensor, 1 when pos == POS_MAX
- S2  out  1  home limit sensor, 1 when pos == 0
- pos  out  POS_W  current carriage position
- moving  out  1  1 while in MOVE_FWD or MOVE_REV
- fault  out  1  1 while in FAULT

Behaviour:
- Clocking and reset: one clock `clk`. Reset is asynchronous, active-low, on `rst_n`.
- Reset values: state IDLE, pos 0, prescale count 0, S2 1, S1 0, moving 0, fault 0.
- Output timing: all outputs are registered. S1 and S2 are decoded from the next value of pos, so they change on the same edge as pos.
- State FSM, states IDLE, MOVE_FWD, MOVE_REV, FAULT. Inputs are sampled at every rising edge; priority is top to bottom.
- Any state except FAULT, with A=1 and C=1: go to FAULT. pos is frozen, the prescale count is cleared, and no step happens on that edge.
- IDLE:
  - A=1, C=0, pos < POS_MAX: go to MOVE_FWD, prescale count = 0.
  - C=1, A=0, pos > 0: go to MOVE_REV, prescale count = 0.
  - A at POS_MAX, or C at 0: stay IDLE. This is an end-stop, not a fault.
- MOVE_FWD:
  - The prescale count increments each cycle.
  - On the edge where count == PRESCALE-1: pos <= pos+1, count <= 0.
  - If the new pos == POS_MAX, go to IDLE on the same edge.
- MOVE_REV: same as MOVE_FWD but pos <= pos-1, and go to IDLE when the new pos == 0.
- Command drop while moving (A falls in MOVE_FWD, or C falls in MOVE_REV, opposite command not high):
  - Go to IDLE and clear the count.
  - The partial step is discarded and pos is held.
- Reversal (A=0, C=1 seen in MOVE_FWD, or the mirror case): go to IDLE first. Movement in the new direction starts from IDLE on the following edge.
- FAULT:
  - fault=1, moving=0, pos held.
  - Exit to IDLE only when fault_clr=1 and A=0 and C=0 on the same edge.
  - fault_clr while A or C is high is ignored.
- Step latency: entering MOVE_FWD on edge k gives the first pos increment on edge k+PRESCALE. A full home-to-far-end travel takes POS_MAX*PRESCALE cycles after entry.
- Arithmetic: pos never wraps. The end checks guarantee 0 <= pos <= POS_MAX.
- Prescale counter width: $clog2(PRESCALE).
- Reset mid-motion: carriage returns to pos 0 immediately (S2=1), regardless of state.

Decomposition:
- Shared package `almacen_pkg`:
  - state encoding constants ST_IDLE, ST_FWD, ST_REV, ST_FAULT;
  - default PRESCALE and POS_MAX constants, shared with the sequencer benches.
- Sub-module `almacen_tick`:
  - prescale counter with synchronous clear and enable;
  - emits a one-cycle `step` pulse when count == PRESCALE-1.
- Everything else stays in almacen_planta.

Test Plan (PRESCALE=4, POS_MAX=3):
- Reset release, A=C=0 for 10 cycles -> pos=0, S2=1, S1=0, moving=0, fault=0 throughout.
- A=1 held from edge 0 -> moving=1 from edge 0; pos=1,2,3 at edges 4,8,12; S2 falls at edge 4; S1 rises at edge 12 with moving=0; A still high -> stays IDLE, no fault.
- From pos=3, C=1 for 6 cycles then C=0 -> pos=2 at edge 4, C drop at edge 6 -> IDLE, pos stays 2, count cleared; C=1 again -> next step exactly 4 edges later.
- A=1 then C=1 at cycle 2 of MOVE_FWD -> fault=1, pos unchanged; fault_clr=1 with C still 1 -> stays FAULT; drop A, C, assert fault_clr -> IDLE, fault=0.
- rst_n low mid-travel at pos=2, asynchronous to clk -> pos=0, S2=1, moving=0 immediately, before the next edge.
- C=1 at pos=0 for 20 cycles -> stays IDLE, pos=0, no fault.
